// File: rtl/noc_pkg.sv
// Shared NoC router constants and helpers: port count, direction encoding,
// opposite-side lookup and flit destination field offsets.
package noc_pkg;

    localparam int NUM_PORTS = 5;

    localparam int DIR_N = 0;
    localparam int DIR_E = 1;
    localparam int DIR_S = 2;
    localparam int DIR_W = 3;
    localparam int DIR_L = 4;

    // The local port has no opposite side and maps to itself.
    function automatic int opposite_dir(input int dir);
        case (dir)
            DIR_N:   return DIR_S;
            DIR_S:   return DIR_N;
            DIR_E:   return DIR_W;
            DIR_W:   return DIR_E;
            default: return DIR_L;
        endcase
    endfunction

    // Destination x occupies the top POS_WIDTH bits, y the next POS_WIDTH below.
    function automatic int pos_x_lsb(input int data_width, input int pos_width);
        return data_width - pos_width;
    endfunction

    function automatic int pos_y_lsb(input int data_width, input int pos_width);
        return data_width - 2 * pos_width;
    endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// N-way round-robin arbiter: searches from ptr+1 upward (mod N) and moves the
// pointer onto the winner; the pointer holds on cycles without a grant.
module noc_rr_arbiter #(
    parameter int N = 5,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant,
    output logic         valid
);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        ptr_d = ptr_q;
        sum   = '0;
        idx   = '0;
        if (en) begin
            for (int k = 1; k <= N; k++) begin
                sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
                if (sum >= (PTR_W+1)'(N)) begin
                    sum = sum - (PTR_W+1)'(N);
                end
                idx = sum[PTR_W-1:0];
                if (!valid && req[idx]) begin
                    valid      = 1'b1;
                    grant[idx] = 1'b1;
                    ptr_d      = idx;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= PTR_W'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/noc_out_arbiter.sv
// Output stage of one router direction: round-robin picks one offer per cycle,
// registers it onto the link and pulses clear back to the winner.
// Define NOC_OUTARB_SKID_EN to add a 2-entry skid FIFO behind the output.
module noc_out_arbiter
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = 288,
    parameter int POS_WIDTH  = 4,
    parameter int DIR        = 0,
    parameter int NO_UTURN   = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_data,
    input  logic [NUM_PORTS-1:0]                req_valid,
    output logic [NUM_PORTS-1:0]                clear,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic                                out_valid,
    input  logic                                out_busy
);

    localparam logic [NUM_PORTS-1:0] UTURN_MASK =
        (NO_UTURN == 1 && DIR < DIR_L) ? (NUM_PORTS'(1) << opposite_dir(DIR)) : '0;
    localparam int POS_LSB = pos_y_lsb(DATA_WIDTH, POS_WIDTH);

    logic [NUM_PORTS-1:0]  clear_q, elig, grant;
    logic                  grant_vld, space;
    logic [DATA_WIDTH-1:0] sel_data;

    // Masking by clear_q keeps a switch's stale offer out while it drops its valid.
    assign elig = req_valid & ~clear_q & ~UTURN_MASK;

    noc_rr_arbiter #(.N(NUM_PORTS)) u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   (elig),
        .en    (space),
        .grant (grant),
        .valid (grant_vld)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) sel_data = req_data[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) clear_q <= '0;
        else      clear_q <= grant;
    end

    assign clear = clear_q;

`ifdef NOC_OUTARB_SKID_EN
    logic [1:0][DATA_WIDTH-1:0] fifo_q, fifo_d;
    logic                       rd_q, rd_d, wr_q, wr_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic                       push, pop;

    assign pop   = (cnt_q != 2'd0) && !out_busy;
    assign push  = grant_vld;
    assign space = (cnt_q < 2'd2) || pop;

    always_comb begin
        fifo_d = fifo_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        if (push) begin
            fifo_d[wr_q] = sel_data;
            wr_d         = ~wr_q;
        end
        if (pop) rd_d = ~rd_q;
        cnt_d = cnt_q + 2'(push) - 2'(pop);
    end

    // NOTE: the two skid entries are reset so out_data reads zero after reset like the base register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fifo_q <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            fifo_q <= fifo_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_data  = fifo_q[rd_q];
    assign out_valid = (cnt_q != 2'd0);

    assert property (@(posedge clk) disable iff (!rst)
        (push && cnt_q == 2'd0) |=> out_data[DATA_WIDTH-1:POS_LSB] == $past(sel_data[DATA_WIDTH-1:POS_LSB]));
`else
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;

    assign space = !out_valid_q || !out_busy;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (grant_vld) begin
            out_data_d  = sel_data;
            out_valid_d = 1'b1;
        end else if (!out_busy) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    assert property (@(posedge clk) disable iff (!rst)
        grant_vld |=> out_data[DATA_WIDTH-1:POS_LSB] == $past(sel_data[DATA_WIDTH-1:POS_LSB]));
`endif

    assert property (@(posedge clk) disable iff (!rst) (grant & ~elig) == '0);
    assert property (@(posedge clk) disable iff (!rst) $onehot0(clear_q));

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Directed bench for noc_out_arbiter (DIR = North, U-turn masked) with a
// link scoreboard: expected flits are queued in grant order and popped on transfer.
module tb_noc_out_arbiter;

    localparam int DW = 32;
    localparam logic [DW-1:0] D0 = 32'h0000_00A5;
    localparam logic [DW-1:0] D1 = 32'h1111_0001;
    localparam logic [DW-1:0] D2 = 32'h2222_0002;
    localparam logic [DW-1:0] D3 = 32'h3333_0003;
    localparam logic [DW-1:0] D4 = 32'h4444_0004;

    logic              clk = 1'b0;
    logic              rst;
    logic [4:0][DW-1:0] req_data;
    logic [4:0]        req_valid;
    logic [4:0]        clear;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    noc_out_arbiter #(
        .DATA_WIDTH (DW),
        .POS_WIDTH  (4),
        .DIR        (0),
        .NO_UTURN   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_valid (req_valid),
        .clear     (clear),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_busy  (out_busy)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs; on return the outputs reflect that cycle's decision.
    task automatic cyc(input logic [4:0] v, input logic b);
        req_valid = v;
        out_busy  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [4:0] c);
        check({name, "_valid"}, DW'(out_valid), DW'(v));
        check({name, "_clear"}, DW'(clear), DW'(c));
    endtask

    // Link monitor: a transfer happens at the next rising edge when valid && !busy.
    always @(negedge clk) begin
        if (rst && out_valid && !out_busy) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL link_flit: got %h with no flit expected at %0t", out_data, $time);
            end else begin
                check("link_flit", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        out_busy  = 1'b0;
        req_data  = {D4, D3, D2, D1, D0};
        @(posedge clk);
        #1;

        // Reset held with every input offering.
        cyc(5'b11111, 1'b0);
        cyc(5'b11111, 1'b0);
        expect_out("reset", 1'b0, 5'b00000);
        check("reset_data", out_data, '0);

        // Release: input 2 is the U-turn side, so grants run 0,1,3,4,0,1.
        rst = 1'b1;
        exp_q.push_back(D0); exp_q.push_back(D1); exp_q.push_back(D3);
        exp_q.push_back(D4); exp_q.push_back(D0); exp_q.push_back(D1);
        cyc(5'b11111, 1'b0); expect_out("rr_g0", 1'b1, 5'b00001);
        cyc(5'b11111, 1'b0); expect_out("rr_g1", 1'b1, 5'b00010);
        cyc(5'b11111, 1'b0); expect_out("rr_g3", 1'b1, 5'b01000);
        cyc(5'b11111, 1'b0); expect_out("rr_g4", 1'b1, 5'b10000);
        cyc(5'b11111, 1'b0); expect_out("rr_g0b", 1'b1, 5'b00001);
        cyc(5'b11111, 1'b0); expect_out("rr_g1b", 1'b1, 5'b00010);

        // Only the U-turn input offers: never granted.
        for (int i = 0; i < 4; i++) begin
            cyc(5'b00100, 1'b0);
            expect_out("uturn", 1'b0, 5'b00000);
        end

        // Single input held: one flit per two cycles because of the clear bubble.
        exp_q.push_back(D3); exp_q.push_back(D3);
        cyc(5'b01000, 1'b0); expect_out("single_a", 1'b1, 5'b01000);
        check("single_a_data", out_data, D3);
        cyc(5'b01000, 1'b0); expect_out("single_b", 1'b0, 5'b00000);
        cyc(5'b01000, 1'b0); expect_out("single_c", 1'b1, 5'b01000);
        cyc(5'b01000, 1'b0); expect_out("single_d", 1'b0, 5'b00000);

        // Backpressure: 0xA5 holds on the link, no new grant until released.
        exp_q.push_back(D0); exp_q.push_back(D1);
        cyc(5'b00001, 1'b0); expect_out("busy_load", 1'b1, 5'b00001);
        check("busy_load_data", out_data, D0);
        for (int i = 0; i < 3; i++) begin
            cyc(5'b00010, 1'b1);
            expect_out("busy_hold", 1'b1, 5'b00000);
            check("busy_hold_data", out_data, D0);
        end
        cyc(5'b00010, 1'b0); expect_out("busy_release", 1'b1, 5'b00010);
        check("busy_release_data", out_data, D1);

        // Reset while a flit is stuck behind busy: it is discarded.
        cyc(5'b00000, 1'b1); expect_out("stuck", 1'b1, 5'b00000);
        check("stuck_data", out_data, D1);
        exp_q.delete();
        rst = 1'b0;
        cyc(5'b11111, 1'b1); expect_out("mid_reset", 1'b0, 5'b00000);
        check("mid_reset_data", out_data, '0);
        rst = 1'b1;
        exp_q.push_back(D0);
        cyc(5'b11111, 1'b0); expect_out("ptr_reset", 1'b1, 5'b00001);
        check("ptr_reset_data", out_data, D0);

        // Mixed inputs with one busy cycle; back-to-back after release.
        exp_q.push_back(D1); exp_q.push_back(D3); exp_q.push_back(D4); exp_q.push_back(D1);
        cyc(5'b11010, 1'b0); expect_out("mix_g1", 1'b1, 5'b00010);
        check("mix_g1_data", out_data, D1);
        cyc(5'b11010, 1'b1); expect_out("mix_hold", 1'b1, 5'b00000);
        check("mix_hold_data", out_data, D1);
        cyc(5'b11010, 1'b0); expect_out("mix_g3", 1'b1, 5'b01000);
        check("mix_g3_data", out_data, D3);
        cyc(5'b11010, 1'b0); expect_out("mix_g4", 1'b1, 5'b10000);
        check("mix_g4_data", out_data, D4);
        cyc(5'b11010, 1'b0); expect_out("mix_g1b", 1'b1, 5'b00010);
        check("mix_g1b_data", out_data, D1);
        cyc(5'b00000, 1'b0); expect_out("idle", 1'b0, 5'b00000);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", DW'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
